oam_dma: RTL and testbench

//  CPU-side OAM DMA engine ($4014 style): a host write of a page number copies

---
 rtl/oam_dma.sv | 124 ++++++++++++
 tb/tb_oam_dma.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: on a host write of a page number, halts the CPU and copies
// BYTE_COUNT bytes from {page, index} into the video block's OAM data register,
// one byte per GET/PUT CPU-cycle pair.
module oam_dma #(
   parameter logic [2:0] OAM_DATA_REG = 3'd4,
   parameter int         BYTE_COUNT   = 256
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_cpu_tick,
   input  logic        I_trig_wren,
   input  logic [7:0]  I_trig_data,
   output logic        O_cpu_halt,
   output logic        O_busy,
   output logic [15:0] O_mem_addr,
   output logic        O_mem_rden,
   input  logic [7:0]  I_mem_data,
   output logic [2:0]  O_ppu_addr,
   output logic        O_ppu_wren,
   output logic [7:0]  O_ppu_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE
   } state_t;

   localparam logic [8:0] COUNT_END = 9'(BYTE_COUNT);

   state_t     state;
   logic [7:0] page;
   logic [8:0] index;
   logic [8:0] index_nxt;
   logic       parity;
   logic [7:0] data_latch;

   assign index_nxt = index + 9'd1;

   // The write strobe is only one I_clock wide, so it is qualified by the tick
   assign O_ppu_addr = OAM_DATA_REG;
   assign O_ppu_wren = (state == S_WRITE) && I_cpu_tick;
   assign O_ppu_data = O_ppu_wren ? data_latch : 8'h00;

   // Free-running GET/PUT phase: 0 = GET (read), 1 = PUT (write)
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) parity <= 1'b0;
      else if (I_cpu_tick) parity <= ~parity;
   end

   // Transfer FSM; halt/busy/read strobe/address are registered with the state
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         state      <= S_IDLE;
         page       <= 8'h00;
         index      <= 9'd0;
         data_latch <= 8'h00;
         O_cpu_halt <= 1'b0;
         O_busy     <= 1'b0;
         O_mem_rden <= 1'b0;
         O_mem_addr <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               // Trigger is sampled on any clock, not just on a tick
               if (I_trig_wren) begin
                  page       <= I_trig_data;
                  index      <= 9'd0;
                  state      <= S_HALT;
                  O_cpu_halt <= 1'b1;
                  O_busy     <= 1'b1;
               end
            end
            S_HALT: begin
               if (I_cpu_tick) begin
                  // parity 1 now means the next tick is a GET: read straight away
                  if (parity) begin
                     state      <= S_READ;
                     O_mem_rden <= 1'b1;
                     O_mem_addr <= {page, index[7:0]};
                  end else begin
                     state <= S_ALIGN;
                  end
               end
            end
            S_ALIGN: begin
               if (I_cpu_tick) begin
                  state      <= S_READ;
                  O_mem_rden <= 1'b1;
                  O_mem_addr <= {page, index[7:0]};
               end
            end
            S_READ: begin
               if (I_cpu_tick) begin
                  data_latch <= I_mem_data;
                  state      <= S_WRITE;
                  O_mem_rden <= 1'b0;
                  O_mem_addr <= 16'h0000;
               end
            end
            S_WRITE: begin
               if (I_cpu_tick) begin
                  index <= index_nxt;
                  if (index_nxt == COUNT_END) begin
                     state      <= S_DONE;
                     O_cpu_halt <= 1'b0;
                  end else begin
                     // Only the low byte reaches the bus; page never carries
                     state      <= S_READ;
                     O_mem_rden <= 1'b1;
                     O_mem_addr <= {page, index_nxt[7:0]};
                  end
               end
            end
            S_DONE: begin
               if (I_cpu_tick) begin
                  state  <= S_IDLE;
                  O_busy <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: random CPU tick spacing and random source
// memory, checked against a byte-list model of what a transfer must produce.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        trig_wren;
   logic [7:0]  trig_data;
   logic        halt;
   logic        busy;
   logic [15:0] mem_addr;
   logic        rden;
   logic [7:0]  mem_data;
   logic [2:0]  ppu_addr;
   logic        wren;
   logic [7:0]  ppu_data;

   logic [7:0]  mem [0:65535];

   int errors = 0;
   int checks = 0;

   bit          tick_en;
   bit          tb_par;
   bit          arm;
   bit          want_first;
   bit          first_par;
   logic [7:0]  wr_q [$];
   logic [15:0] rd_q [$];
   int          halt_ticks;
   int          rd_par_err;
   int          wren_err;

   oam_dma dut (
      .I_clock     (clk),
      .I_reset     (rst),
      .I_cpu_tick  (tick),
      .I_trig_wren (trig_wren),
      .I_trig_data (trig_data),
      .O_cpu_halt  (halt),
      .O_busy      (busy),
      .O_mem_addr  (mem_addr),
      .O_mem_rden  (rden),
      .I_mem_data  (mem_data),
      .O_ppu_addr  (ppu_addr),
      .O_ppu_wren  (wren),
      .O_ppu_data  (ppu_data)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr];

   // CPU tick: single-clock pulses with random spacing
   always @(posedge clk) begin
      #1;
      tick = tick_en && !tick && ($urandom_range(0, 1) == 1);
   end

   // Observer: GET/PUT phase model, write/read logs and halted-tick count
   always @(negedge clk) begin
      if (rst) begin
         tb_par = 1'b0;
      end else begin
         if (tick) begin
            if (want_first) begin
               first_par  = tb_par;
               want_first = 1'b0;
            end
            if (halt) halt_ticks++;
            if (rden) begin
               rd_q.push_back(mem_addr);
               if (tb_par) rd_par_err++;
            end
         end
         if (wren) begin
            wr_q.push_back(ppu_data);
            if (!tick) wren_err++;
         end
         if (trig_wren && arm) begin
            want_first = 1'b1;
            arm        = 1'b0;
         end
         if (tick) tb_par = ~tb_par;
      end
   end

   task automatic clear_logs();
      wr_q.delete();
      rd_q.delete();
      halt_ticks = 0;
      rd_par_err = 0;
      wren_err   = 0;
      want_first = 1'b0;
   endtask

   // Fire an accepted trigger so that the HALT dummy tick has phase dummy_par
   task automatic trigger(input logic [7:0] pg, input bit dummy_par);
      int n = 0;
      clear_logs();
      do begin
         @(posedge clk); #2;
         n++;
      end while (((tick ? ~tb_par : tb_par) != dummy_par) && n < 200);
      arm       = 1'b1;
      trig_data = pg;
      trig_wren = 1'b1;
      @(posedge clk); #2;
      trig_wren = 1'b0;
      arm       = 1'b0;
   endtask

   task automatic wait_bytes(input string name, input int nbytes);
      int n = 0;
      while (wr_q.size() < nbytes && n < 6000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wr_q.size() < nbytes) begin
         errors++;
         $display("FAIL %s: byte count %0d, need %0d before timeout", name, wr_q.size(), nbytes);
      end
   endtask

   // Wait for completion, then compare the logs with the expected page copy
   task automatic verify_xfer(input string name, input logic [7:0] pg, input int exp_halt);
      int n = 0;
      int bad_d = 0;
      int bad_a = 0;
      int first_bad = -1;
      int want_halt;
      while (busy !== 1'b0 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: busy still %b after timeout", name, busy);
      end
      repeat (30) @(negedge clk);
      want_halt = (exp_halt != 0) ? exp_halt : (first_par ? 513 : 514);

      checks++;
      if (wr_q.size() != 256 || rd_q.size() != 256) begin
         errors++;
         $display("FAIL %s_count: writes %0d reads %0d, need 256 each", name, wr_q.size(), rd_q.size());
      end
      for (int i = 0; i < 256; i++) begin
         logic [15:0] a;
         a = {pg, 8'(i)};
         if (i < wr_q.size() && wr_q[i] !== mem[a]) begin
            bad_d++;
            if (first_bad < 0) first_bad = i;
         end
         if (i < rd_q.size() && rd_q[i] !== a) bad_a++;
      end
      checks++;
      if (bad_d != 0) begin
         errors++;
         $display("FAIL %s_data: %0d wrong bytes, first at %0d (got %h need %h)", name, bad_d,
                  first_bad, wr_q[first_bad], mem[{pg, 8'(first_bad)}]);
      end
      checks++;
      if (bad_a != 0) begin
         errors++;
         $display("FAIL %s_addr: %0d read addresses off page %h", name, bad_a, pg);
      end
      checks++;
      if (halt_ticks != want_halt) begin
         errors++;
         $display("FAIL %s_halt: halted ticks %0d, need %0d", name, halt_ticks, want_halt);
      end
      checks++;
      if (rd_par_err != 0 || wren_err != 0) begin
         errors++;
         $display("FAIL %s_phase: reads on PUT %0d, untimed writes %0d, need 0", name, rd_par_err, wren_err);
      end
      checks++;
      if ({halt, busy, rden} !== 3'b000) begin
         errors++;
         $display("FAIL %s_idle: halt/busy/rden %b, need 000", name, {halt, busy, rden});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick_en = 1'b0; tick = 1'b0; trig_wren = 1'b0; trig_data = 8'h00;
      arm = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({halt, busy, rden, wren, mem_addr, ppu_data} !== 28'h0) begin
         errors++;
         $display("FAIL reset_outs: got %h need 0", {halt, busy, rden, wren, mem_addr, ppu_data});
      end
      checks++;
      if (ppu_addr !== 3'd4) begin
         errors++;
         $display("FAIL reset_ppu_addr: got %0d need 4", ppu_addr);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      tick_en = 1'b1;
   endtask

   task automatic test_misaligned();
      trigger(8'h02, 1'b0);
      verify_xfer("misaligned", 8'h02, 514);
   endtask

   task automatic test_aligned();
      trigger(8'h02, 1'b1);
      verify_xfer("aligned", 8'h02, 513);
   endtask

   task automatic test_retrigger();
      trigger(8'h03, 1'($urandom_range(0, 1)));
      wait_bytes("retrig_wait", 100);
      @(posedge clk); #2;
      trig_data = 8'h07;
      trig_wren = 1'b1;
      @(posedge clk); #2;
      trig_wren = 1'b0;
      verify_xfer("retrigger", 8'h03, 0);
   endtask

   task automatic test_page_ff();
      trigger(8'hFF, 1'($urandom_range(0, 1)));
      verify_xfer("page_ff", 8'hFF, 0);
      checks++;
      if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== 16'hFFFF) begin
         errors++;
         $display("FAIL page_ff_last: last read %h need ffff", (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 16'h0);
      end
   endtask

   task automatic test_mid_reset();
      int nw;
      trigger(8'h09, 1'($urandom_range(0, 1)));
      wait_bytes("reset_wait", 37);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({halt, busy, rden, wren, mem_addr, ppu_data} !== 28'h0) begin
         errors++;
         $display("FAIL midreset_outs: got %h need 0", {halt, busy, rden, wren, mem_addr, ppu_data});
      end
      @(posedge clk); #2;
      rst = 1'b0;
      nw = wr_q.size();
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_q.size() != nw) begin
         errors++;
         $display("FAIL midreset_abandon: busy %b writes %0d, need 0 and %0d", busy, wr_q.size(), nw);
      end
      trigger(8'h04, 1'($urandom_range(0, 1)));
      verify_xfer("after_reset", 8'h04, 0);
   endtask

   task automatic test_tick_freeze();
      logic [18:0] snap;
      int nw, nr, drift;
      trigger(8'h05, 1'($urandom_range(0, 1)));
      wait_bytes("freeze_wait", 50);
      @(posedge clk); #2;
      tick_en = 1'b0;
      @(posedge clk); #2;
      snap  = {halt, busy, rden, mem_addr};
      nw    = wr_q.size();
      nr    = rd_q.size();
      drift = 0;
      repeat (50) begin
         @(negedge clk);
         if ({halt, busy, rden, mem_addr} !== snap || wren !== 1'b0) drift++;
      end
      checks++;
      if (drift != 0 || wr_q.size() != nw || rd_q.size() != nr) begin
         errors++;
         $display("FAIL freeze_hold: %0d changed cycles, writes %0d->%0d", drift, nw, wr_q.size());
      end
      tick_en = 1'b1;
      verify_xfer("freeze", 8'h05, 0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      test_reset();
      test_misaligned();
      test_aligned();
      test_retrigger();
      test_page_ff();
      test_mid_reset();
      test_tick_freeze();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
